// File: rtl/playback_ctrl.sv
// Song playback sequencer: STOP/PLAY/PAUSE/DONE control of the beat index, plus volume level and LED bar.
// The loop-at-end input is named repeat_en because "repeat" is a reserved word.
module playback_ctrl #(
    parameter int unsigned LEN0    = 128,
    parameter int unsigned LEN1    = 128,
    parameter int unsigned VOL_RST = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        play,
    input  logic        repeat_en,
    input  logic        music_sel,
    input  logic        mute,
    input  logic        vol_up,
    input  logic        vol_down,
    output logic [11:0] ibeat,
    output logic        song,
    output logic [2:0]  volume,
    output logic [4:0]  led_vol,
    output logic        silent,
    output logic        done
);

    typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_PAUSE, ST_DONE} state_t;

    localparam logic [11:0] LAST0   = 12'(LEN0 - 1);
    localparam logic [11:0] LAST1   = 12'(LEN1 - 1);
    localparam logic [2:0]  VOL_INI = 3'(VOL_RST);
    localparam logic [2:0]  VOL_MAX = 3'd5;
    localparam logic [2:0]  VOL_MIN = 3'd1;

    function automatic logic [4:0] therm(input logic [2:0] v);
        case (v)
            3'd1:    therm = 5'b00001;
            3'd2:    therm = 5'b00011;
            3'd3:    therm = 5'b00111;
            3'd4:    therm = 5'b01111;
            3'd5:    therm = 5'b11111;
            default: therm = 5'b00000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [11:0] ibeat_q, ibeat_d;
    logic        song_q, song_d;
    logic [2:0]  volume_q, volume_d;
    logic [4:0]  led_vol_q, led_vol_d;
    logic        silent_q, silent_d;
    logic        done_q, done_d;
    logic [11:0] last;

    always_comb begin
        state_d  = state_q;
        ibeat_d  = ibeat_q;
        song_d   = song_q;
        volume_d = volume_q;
        last     = song_q ? LAST1 : LAST0;

        // A song switch takes priority over every per-state transition.
        if (music_sel != song_q) begin
            song_d  = music_sel;
            ibeat_d = '0;
            state_d = play ? ST_PLAY : ST_STOP;
        end else begin
            case (state_q)
                ST_STOP: begin
                    ibeat_d = '0;
                    if (play) state_d = ST_PLAY;
                end
                ST_PLAY: begin
                    if (!play) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        if (ibeat_q == last) begin
                            if (repeat_en) ibeat_d = '0;
                            else           state_d = ST_DONE;
                        end else begin
                            ibeat_d = ibeat_q + 12'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (play) state_d = ST_PLAY;
                end
                ST_DONE: begin
                    if (!play) begin
                        state_d = ST_STOP;
                        ibeat_d = '0;
                    end else if (repeat_en) begin
                        state_d = ST_PLAY;
                        ibeat_d = '0;
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end

        if (vol_up && !vol_down && volume_q != VOL_MAX)
            volume_d = volume_q + 3'd1;
        else if (vol_down && !vol_up && volume_q != VOL_MIN)
            volume_d = volume_q - 3'd1;

        led_vol_d = mute ? 5'b00000 : therm(volume_d);
        silent_d  = mute || (state_d != ST_PLAY);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_STOP;
            ibeat_q   <= '0;
            song_q    <= 1'b0;
            volume_q  <= VOL_INI;
            led_vol_q <= mute ? 5'b00000 : therm(VOL_INI);
            silent_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ibeat_q   <= ibeat_d;
            song_q    <= song_d;
            volume_q  <= volume_d;
            led_vol_q <= led_vol_d;
            silent_q  <= silent_d;
            done_q    <= done_d;
        end
    end

    assign ibeat   = ibeat_q;
    assign song    = song_q;
    assign volume  = volume_q;
    assign led_vol = led_vol_q;
    assign silent  = silent_q;
    assign done    = done_q;

endmodule

// File: doc/playback_ctrl.md
PLAYBACK_CTRL -- requirements
Module: playback_ctrl

Interface
REQ-001 SHALL have parameter LEN0, default 128, beat count of song 0 (2..4096).
REQ-002 SHALL have parameter LEN1, default 128, beat count of song 1 (2..4096).
REQ-003 SHALL have parameter VOL_RST, default 3, volume level after reset (1..5).
REQ-004 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port tick  input  1  beat-advance strobe, one clk wide.
REQ-007 SHALL have port play  input  1  level: 1 = play, 0 = pause/stop request.
REQ-008 SHALL have port repeat  input  1  level: 1 = loop song at end.
REQ-009 SHALL have port music_sel  input  1  level: requested song index.
REQ-010 SHALL have port mute  input  1  level: force silence.
REQ-011 SHALL have port vol_up  input  1  one-clk pulse, already debounced and one-pulsed.
REQ-012 SHALL have port vol_down  input  1  one-clk pulse, already debounced and one-pulsed.
REQ-013 SHALL have port ibeat  output  12  current beat index into music table.
REQ-014 SHALL have port song  output  1  latched active song index.
REQ-015 SHALL have port volume  output  3  volume level, 1..5.
REQ-016 SHALL have port led_vol  output  5  thermometer volume bar.
REQ-017 SHALL have port silent  output  1  1 = datapath must output silence.
REQ-018 SHALL have port done  output  1  1 while in DONE state.

Function
REQ-019 SHALL register every output; no combinational input-to-output path.
REQ-020 SHALL implement FSM states STOP, PLAY, PAUSE, DONE.
REQ-021 SHALL use active length L = LEN1 when song=1, else LEN0.
REQ-022 STOP: play=1 -> PLAY with ibeat=0; otherwise hold, ibeat=0.
REQ-023 PLAY: play=0 -> PAUSE, ibeat held, tick in same cycle ignored.
REQ-024 PLAY, play=1, tick=1, ibeat<L-1: ibeat+1 on the next edge (latency 1 clk).
REQ-025 PLAY, play=1, tick=1, ibeat=L-1: repeat=1 -> ibeat=0, stay PLAY; repeat=0 -> DONE, ibeat held at L-1.
REQ-026 PAUSE: play=1 -> PLAY, ibeat unchanged; tick ignored.
REQ-027 DONE: play=0 -> STOP, ibeat=0; else repeat=1 -> PLAY, ibeat=0; else hold.
REQ-028 Song change (music_sel != song) in any state: song<=music_sel, ibeat<=0, state <= PLAY if play=1 else STOP; overrides REQ-022..027 that cycle.
REQ-029 volume SHALL increment on vol_up, saturating at 5.
REQ-030 volume SHALL decrement on vol_down, saturating at 1.
REQ-031 vol_up and vol_down in the same cycle: volume unchanged.
REQ-032 Volume changes SHALL apply in all FSM states, and while muted.
REQ-033 led_vol SHALL be low volume bits set (level n -> n ones from bit 0); 5'b00000 when mute=1.
REQ-034 silent SHALL be 1 when mute=1 or state != PLAY.
REQ-035 done SHALL be 1 exactly while state=DONE.
REQ-036 ibeat SHALL never exceed L-1; L change via song switch always resets ibeat to 0.

Reset
REQ-037 rst=0 at a clk edge: state=STOP, ibeat=0, song=0, volume=VOL_RST, done=0, silent=1.
REQ-038 led_vol SHALL reflect VOL_RST (5'b00111 for default) unless mute=1.
REQ-039 Reset SHALL override all inputs, including mid-song and coincident tick/vol pulses.

Verification
REQ-040 Reset, play=1, 5 ticks -> ibeat 0,1,2,3,4,5, each one clk after its tick; silent=0.
REQ-041 LEN0=4, repeat=0, play=1, 4 ticks -> ibeat 3, then DONE, done=1, silent=1; extra ticks no change; repeat=1 -> PLAY, ibeat=0.
REQ-042 At ibeat=2, play=0 with coincident tick -> PAUSE, ibeat=2; play=1 then tick -> ibeat=3.
REQ-043 At ibeat=50, music_sel 0->1 with coincident tick -> song=1, ibeat=0, state PLAY.
REQ-044 From volume 3: three vol_up -> 4,5,5; vol_up+vol_down together -> 5; five vol_down -> 1; led_vol 5'b00001; mute=1 -> led_vol 0, silent=1.
REQ-045 rst=0 asserted mid-PLAY at ibeat=7, volume=5 -> next edge ibeat=0, volume=3, STOP, silent=1.
